// File: rtl/wb_cmd_packer.sv
`timescale 1ns/1ps
// Packs a serial byte stream into 34-bit {type, payload} command words for the
// Wishbone bus master, aborting stalled payloads after an inter-byte timeout.
module wb_cmd_packer #(
  parameter int TIMEOUT = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  output logic        o_busy,
  output logic        o_cmd_stb,
  output logic [33:0] o_cmd_word,
  input  logic        i_cmd_busy,
  output logic        o_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [23:0]   payload_q, payload_d;
  logic [33:0]   word_q, word_d;
  logic          err_q, err_d;
  logic          accept;

  assign accept     = i_stb && (state_q != S_EMIT);
  assign o_busy     = (state_q == S_EMIT);
  assign o_cmd_stb  = (state_q == S_EMIT);
  assign o_cmd_word = word_q;
  assign o_err      = err_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      type_q    <= 2'b00;
      cnt_q     <= 2'd0;
      tmo_q     <= '0;
      payload_q <= 24'h0;
      word_q    <= 34'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
      word_q    <= word_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    payload_d = payload_q;
    word_d    = word_q;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (i_byte[7:6])
            2'b00: begin
              word_d  = 34'h0;
              state_d = S_EMIT;
            end
            2'b11: begin
              word_d  = {2'b11, 26'h0, i_byte[5:0]};
              state_d = S_EMIT;
            end
            default: begin
              type_d  = i_byte[7:6];
              cnt_d   = 2'd0;
              tmo_d   = '0;
              state_d = S_PAYLOAD;
            end
          endcase
        end
      end

      S_PAYLOAD: begin
        // An arriving byte always takes priority over the timeout expiring.
        if (accept) begin
          payload_d = {payload_q[15:0], i_byte};
          cnt_d     = cnt_q + 2'd1;
          tmo_d     = '0;
          if (cnt_q == 2'd3) begin
            word_d  = {type_q, payload_q, i_byte};
            state_d = S_EMIT;
          end
        end else if (tmo_q == TMO_LAST) begin
          payload_d = 24'h0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end

      S_EMIT: begin
        if (!i_cmd_busy) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cmd_packer.sv
`timescale 1ns/1ps
// Directed bench for wb_cmd_packer with TIMEOUT = 4; a monitor logs every word
// transfer and error pulse, and each scenario task checks its own results.
module tb_wb_cmd_packer;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_busy;
  logic        o_cmd_stb;
  logic [33:0] o_cmd_word;
  logic        i_cmd_busy = 1'b0;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [33:0] xfer_q[$];

  wb_cmd_packer #(.TIMEOUT(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_stb      (i_stb),
    .i_byte     (i_byte),
    .o_busy     (o_busy),
    .o_cmd_stb  (o_cmd_stb),
    .o_cmd_word (o_cmd_word),
    .i_cmd_busy (i_cmd_busy),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_cmd_stb && !i_cmd_busy) begin
      xfer_q.push_back(o_cmd_word);
      $display("[%0t] xfer word=%h", $time, o_cmd_word);
    end
    if (o_err) begin
      err_cnt++;
      $display("[%0t] err pulse", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one byte and holds it until the edge where it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    i_stb  = 1'b1;
    i_byte = b;
    guard  = 0;
    while (o_busy && guard < 20) begin
      step();
      guard++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: busy=%b required 0", o_busy);
    end
    step();
    i_stb = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    checks++; if (o_cmd_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b required 0", o_cmd_stb); end
    checks++; if (o_cmd_word !== 34'h0) begin errors++; $display("FAIL reset_word: got %h required 0", o_cmd_word); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", o_err); end
    step();
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    int n0;
    n0 = xfer_q.size();
    i_cmd_busy = 1'b0;
    send_byte(8'h00);
    checks++; if (o_cmd_stb !== 1'b1) begin errors++; $display("FAIL read_stb: got %b required 1", o_cmd_stb); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b required 1", o_busy); end
    checks++; if (o_cmd_word !== 34'h0) begin errors++; $display("FAIL read_word: got %h required 0", o_cmd_word); end
    step();
    checks++; if (o_busy !== 1'b0 || o_cmd_stb !== 1'b0) begin errors++; $display("FAIL read_release: busy=%b stb=%b required 0 0", o_busy, o_cmd_stb); end
    checks++; if (xfer_q.size() != n0 + 1) begin errors++; $display("FAIL read_count: got %0d required %0d", xfer_q.size() - n0, 1); end
    else begin
      checks++; if (xfer_q[n0] !== 34'h0) begin errors++; $display("FAIL read_xfer_word: got %h required 0", xfer_q[n0]); end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [33:0] exp_w, exp_a;
    exp_w = {2'b01, 32'hDEADBEEF};
    exp_a = {2'b10, 32'h00001000};
    n0 = xfer_q.size();
    send_byte(8'h40); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== exp_w) begin errors++; $display("FAIL b2b_write_word: stb=%b word=%h required 1 %h", o_cmd_stb, o_cmd_word, exp_w); end
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== exp_a) begin errors++; $display("FAIL b2b_addr_word: stb=%b word=%h required 1 %h", o_cmd_stb, o_cmd_word, exp_a); end
    step();
    checks++; if (xfer_q.size() != n0 + 2) begin errors++; $display("FAIL b2b_count: got %0d required 2", xfer_q.size() - n0); end
    else begin
      checks++; if (xfer_q[n0] !== exp_w) begin errors++; $display("FAIL b2b_first: got %h required %h", xfer_q[n0], exp_w); end
      checks++; if (xfer_q[n0+1] !== exp_a) begin errors++; $display("FAIL b2b_second: got %h required %h", xfer_q[n0+1], exp_a); end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    logic [33:0] exp_s;
    exp_s = {2'b11, 26'h0, 6'h05};
    n0 = xfer_q.size();
    i_cmd_busy = 1'b1;
    send_byte(8'hC5);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (o_cmd_stb !== 1'b1 || o_busy !== 1'b1 || o_cmd_word !== exp_s) begin
        errors++;
        $display("FAIL bp_hold_%0d: stb=%b busy=%b word=%h required 1 1 %h", k, o_cmd_stb, o_busy, o_cmd_word, exp_s);
      end
      i_stb  = 1'b1;
      i_byte = 8'h00;
      if (k == 7) i_cmd_busy = 1'b0;
      step();
    end
    i_stb = 1'b0;
    checks++; if (o_cmd_stb !== 1'b0) begin errors++; $display("FAIL bp_release: stb=%b required 0", o_cmd_stb); end
    step();
    checks++; if (o_cmd_stb !== 1'b0) begin errors++; $display("FAIL bp_no_accept: stb=%b required 0", o_cmd_stb); end
    checks++; if (xfer_q.size() != n0 + 1) begin errors++; $display("FAIL bp_count: got %0d required 1", xfer_q.size() - n0); end
    else begin
      checks++; if (xfer_q[n0] !== exp_s) begin errors++; $display("FAIL bp_word: got %h required %h", xfer_q[n0], exp_s); end
    end
  endtask

  task automatic test_timeout();
    int n0, e0;
    n0 = xfer_q.size();
    e0 = err_cnt;
    send_byte(8'h40); send_byte(8'h11); send_byte(8'h22);
    step(); step(); step();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL tmo_early: err=%b required 0", o_err); end
    step();
    checks++; if (o_err !== 1'b1 || o_cmd_stb !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL tmo_pulse: err=%b stb=%b busy=%b required 1 0 0", o_err, o_cmd_stb, o_busy); end
    step();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: err=%b required 0", o_err); end
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL tmo_err_count: got %0d required 1", err_cnt - e0); end
    checks++; if (xfer_q.size() != n0) begin errors++; $display("FAIL tmo_no_word: got %0d required 0", xfer_q.size() - n0); end
    send_byte(8'h00);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== 34'h0) begin errors++; $display("FAIL tmo_next_read: stb=%b word=%h required 1 0", o_cmd_stb, o_cmd_word); end
    step();
    checks++; if (xfer_q.size() != n0 + 1) begin errors++; $display("FAIL tmo_next_count: got %0d required 1", xfer_q.size() - n0); end
  endtask

  task automatic test_timeout_byte_wins();
    int n0, e0;
    logic [33:0] exp_w;
    exp_w = {2'b01, 32'h11223344};
    n0 = xfer_q.size();
    e0 = err_cnt;
    send_byte(8'h40); send_byte(8'h11); send_byte(8'h22);
    step(); step(); step();
    send_byte(8'h33);
    send_byte(8'h44);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== exp_w) begin errors++; $display("FAIL tmo_edge_word: stb=%b word=%h required 1 %h", o_cmd_stb, o_cmd_word, exp_w); end
    step();
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL tmo_edge_err: got %0d pulses required 0", err_cnt - e0); end
    checks++; if (xfer_q.size() != n0 + 1) begin errors++; $display("FAIL tmo_edge_count: got %0d required 1", xfer_q.size() - n0); end
  endtask

  task automatic test_async_reset();
    int n0;
    logic [33:0] exp_a;
    exp_a = {2'b10, 32'h12345678};
    n0 = xfer_q.size();
    send_byte(8'h40); send_byte(8'hAA); send_byte(8'hBB);
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_cmd_word !== 34'h0 || o_cmd_stb !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL arst_payload_outputs: word=%h stb=%b busy=%b err=%b required 0 0 0 0", o_cmd_word, o_cmd_stb, o_busy, o_err); end
    step();
    i_reset = 1'b0;
    send_byte(8'h00);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== 34'h0) begin errors++; $display("FAIL arst_after_payload_read: stb=%b word=%h required 1 0", o_cmd_stb, o_cmd_word); end
    step();
    i_cmd_busy = 1'b1;
    send_byte(8'hC5);
    checks++; if (o_cmd_stb !== 1'b1) begin errors++; $display("FAIL arst_emit_setup: stb=%b required 1", o_cmd_stb); end
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_cmd_word !== 34'h0 || o_cmd_stb !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL arst_emit_outputs: word=%h stb=%b busy=%b err=%b required 0 0 0 0", o_cmd_word, o_cmd_stb, o_busy, o_err); end
    i_cmd_busy = 1'b0;
    step();
    i_reset = 1'b0;
    step();
    checks++; if (xfer_q.size() != n0 + 1) begin errors++; $display("FAIL arst_dropped: got %0d words required 1", xfer_q.size() - n0); end
    send_byte(8'h80); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    checks++; if (o_cmd_stb !== 1'b1 || o_cmd_word !== exp_a) begin errors++; $display("FAIL arst_recover_word: stb=%b word=%h required 1 %h", o_cmd_stb, o_cmd_word, exp_a); end
    step();
    checks++; if (xfer_q.size() != n0 + 2) begin errors++; $display("FAIL arst_recover_count: got %0d required 2", xfer_q.size() - n0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_read();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_timeout_byte_wins();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_packer.md
# wb_cmd_packer

Byte-to-command packer sitting directly upstream of the Wishbone bus master. It collects a serial byte stream (typically from the UART receiver) into 34-bit command words: top 2 bits are the command type, low 32 bits are the payload. It presents each word on a strobe/busy handshake that connects straight to the master's `i_stb`/`i_word`/`o_busy`. Partially received commands that stall are aborted by an inter-byte timeout.

## Interface
- `TIMEOUT`, default 1000: consecutive byte-less cycles allowed inside a payload before abort. Legal range ≥ 2.
- `CW`, default `$clog2(TIMEOUT)`: timeout counter width (localparam).

Ports:
- `i_clk` in 1: single clock, all logic on rising edge.
- `i_reset` in 1: reset, asynchronous, active-high.
- `i_stb` in 1: input byte valid.
- `i_byte` in 8: input byte.
- `o_busy` out 1: byte backpressure. A byte is accepted on an edge where `i_stb && !o_busy`.
- `o_cmd_stb` out 1: command word valid, toward the master's `i_stb`.
- `o_cmd_word` out 34: command word, toward the master's `i_word`.
- `i_cmd_busy` in 1: master busy, from the master's `o_busy`. A word transfers on an edge where `o_cmd_stb && !i_cmd_busy`.
- `o_err` out 1: one-cycle pulse on timeout abort.

## Operation
- Header byte `H`: `H[7:6]` gives the type.
  - `00` read: no payload; word = `{2'b00, 32'h0}`.
  - `01` write: 4 payload bytes; word = `{2'b01, P}`.
  - `10` set-address: 4 payload bytes; word = `{2'b10, P}`.
  - `11` special: no payload; word = `{2'b11, 26'h0, H[5:0]}`.
- Payload `P` is big-endian: the first payload byte lands in `P[31:24]`, the last in `P[7:0]`.
- State machine:
  - IDLE: accept header.
    - Read/special: load `o_cmd_word`, go to EMIT.
    - Write/addr: latch type, clear byte counter (2 bits) and timeout counter, go to PAYLOAD.
  - PAYLOAD: each accepted byte shifts into the payload register, increments the byte counter, and clears the timeout counter.
    - On the 4th byte: load `o_cmd_word`, go to EMIT.
    - A cycle with no accepted byte increments the timeout counter.
    - When the counter equals `TIMEOUT-1` and no byte arrives that cycle: go to IDLE, pulse `o_err`, discard the partial payload.
  - EMIT: `o_cmd_stb` = 1 and `o_cmd_word` is held stable. On transfer, go to IDLE.
- `o_busy` = 1 exactly while in EMIT. Bytes are never accepted in EMIT and are never lost.
- `H[5:0]` is ignored for read/write/addr.

## Timing
- Reset values (asynchronous): state IDLE; `o_busy` 0, `o_cmd_stb` 0, `o_cmd_word` 0, `o_err` 0; all counters 0.
- Reset asserted mid-payload or mid-EMIT: the command is dropped and no word is emitted.
- Latency: final byte of a command accepted at edge N gives `o_cmd_stb` = 1 and `o_busy` = 1 after edge N.
- If `i_cmd_busy` = 0, the transfer occurs at edge N+1 and a new header is accepted from edge N+2 onward.
- Throughput: 2 cycles per read/special command and 6 cycles per write/addr command at full byte rate.
- `o_cmd_stb` stays high until transfer, even with `i_cmd_busy` held high indefinitely. `o_cmd_word` is constant for the whole time `o_cmd_stb` is high.
- Timeout: after the last accepted byte, `TIMEOUT` consecutive idle cycles lead to abort. `o_err` is high for exactly one cycle, the cycle after the abort edge, and the block is in IDLE at the same time.
- A byte arriving on the cycle the counter reaches `TIMEOUT-1` is accepted; the byte wins over the timeout.
- No timeout runs in IDLE or EMIT.
- `o_err` and `o_cmd_stb` are never high together.

## Test plan
- Read command: byte `8'h00` with `i_cmd_busy` = 0 → one cycle later `o_cmd_stb` = 1 and `o_cmd_word` = `34'h0_0000_0000`, transferred next edge; `o_busy` high for 1 cycle.
- Back-to-back write: bytes `8'h40, DE, AD, BE, EF` on consecutive cycles → `o_cmd_word` = `{2'b01, 32'hDEADBEEF}`.
  - Then set-address `8'h80, 00, 00, 10, 00` → `{2'b10, 32'h00001000}`, in that order with no loss.
- Backpressure: special `8'hC5` with `i_cmd_busy` = 1 for 7 cycles → `o_cmd_stb` and `{2'b11, 26'h0, 6'h05}` held for 8 cycles, single transfer; `i_stb` asserted during EMIT is not accepted.
- Timeout: `TIMEOUT` = 4; send `8'h40, 11, 22` then idle → `o_err` pulses once, no `o_cmd_stb`.
  - Next `8'h00` → read word emitted normally.
  - Variant: a byte arrives on the 4th idle cycle → no abort.
- Async reset: assert `i_reset` after the 2nd payload byte and again during EMIT → all outputs 0 immediately, no word emitted.
  - After release, the next full command is emitted correctly.
